// File: rtl/s2_maxpool.sv
// s2_maxpool: 2x2 stride-2 max-pooling stage for six parallel channels.
// Pixels arrive in raster order, one per accepted cycle. The horizontal
// pair maximum of an even row is parked in a line buffer. It is combined
// with the matching pair of the following odd row to form one pooled
// output per 2x2 block. The result is written to the F3 RAM one cycle
// after the block's last pixel.
module s2_maxpool #(
    parameter int DATA_W = 16,
    parameter int IN_DIM = 28
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              c1_valid,
    input  logic [DATA_W-1:0] c1_1_data,
    input  logic [DATA_W-1:0] c1_2_data,
    input  logic [DATA_W-1:0] c1_3_data,
    input  logic [DATA_W-1:0] c1_4_data,
    input  logic [DATA_W-1:0] c1_5_data,
    input  logic [DATA_W-1:0] c1_6_data,
    output logic              f3_wr_en,
    output logic [7:0]        f3_waddr,
    output logic [DATA_W-1:0] f3_1_wdata,
    output logic [DATA_W-1:0] f3_2_wdata,
    output logic [DATA_W-1:0] f3_3_wdata,
    output logic [DATA_W-1:0] f3_4_wdata,
    output logic [DATA_W-1:0] f3_5_wdata,
    output logic [DATA_W-1:0] f3_6_wdata,
    output logic              busy,
    output logic              pool_done
);

    localparam int HALF = IN_DIM / 2;
    localparam int CW   = $clog2(IN_DIM);
    localparam int NCH  = 6;

    logic [CW-1:0] col;
    logic [CW-1:0] row;
    logic          last_col;
    logic          last_row;
    logic [7:0]    addr_calc;

    logic signed [DATA_W-1:0] in_data [NCH];
    logic signed [DATA_W-1:0] held    [NCH];
    logic signed [DATA_W-1:0] hmax    [NCH];
    logic signed [DATA_W-1:0] lb_rd   [NCH];
    logic signed [DATA_W-1:0] pooled  [NCH];
    logic signed [DATA_W-1:0] wdata_q [NCH];
    logic signed [DATA_W-1:0] line_buf [HALF][NCH];

    assign in_data[0] = c1_1_data;
    assign in_data[1] = c1_2_data;
    assign in_data[2] = c1_3_data;
    assign in_data[3] = c1_4_data;
    assign in_data[4] = c1_5_data;
    assign in_data[5] = c1_6_data;

    assign f3_1_wdata = wdata_q[0];
    assign f3_2_wdata = wdata_q[1];
    assign f3_3_wdata = wdata_q[2];
    assign f3_4_wdata = wdata_q[3];
    assign f3_5_wdata = wdata_q[4];
    assign f3_6_wdata = wdata_q[5];

    assign last_col  = (col == CW'(IN_DIM - 1));
    assign last_row  = (row == CW'(IN_DIM - 1));
    assign addr_calc = 8'((int'(row) >> 1) * HALF + (int'(col) >> 1));

    // Signed horizontal pair max and the full 2x2 block max, per channel
    always_comb begin
        for (int k = 0; k < NCH; k++) begin
            hmax[k]   = (in_data[k] > held[k]) ? in_data[k] : held[k];
            lb_rd[k]  = line_buf[col[CW-1:1]][k];
            pooled[k] = (lb_rd[k] > hmax[k]) ? lb_rd[k] : hmax[k];
        end
    end

    // Sample holding register and line buffer; contents need no reset
    always_ff @(posedge clk) begin
        if (c1_valid && !rst) begin
            for (int k = 0; k < NCH; k++) begin
                if (!col[0]) begin
                    held[k] <= in_data[k];
                end else if (!row[0]) begin
                    line_buf[col[CW-1:1]][k] <= hmax[k];
                end
            end
        end
    end

    // Raster counters, registered F3 write port, and frame status flags
    always_ff @(posedge clk) begin
        if (rst) begin
            col       <= '0;
            row       <= '0;
            f3_wr_en  <= 1'b0;
            f3_waddr  <= '0;
            busy      <= 1'b0;
            pool_done <= 1'b0;
            for (int k = 0; k < NCH; k++) begin
                wdata_q[k] <= '0;
            end
        end else begin
            f3_wr_en  <= 1'b0;
            pool_done <= 1'b0;
            if (c1_valid) begin
                busy <= !(last_row && last_col);
                if (col[0] && row[0]) begin
                    f3_wr_en  <= 1'b1;
                    f3_waddr  <= addr_calc;
                    pool_done <= last_row && last_col;
                    for (int k = 0; k < NCH; k++) begin
                        wdata_q[k] <= pooled[k];
                    end
                end
                if (last_col) begin
                    col <= '0;
                    row <= last_row ? '0 : row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
            end
        end
    end

endmodule
